gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank_pkg.sv | 36 +++
 rtl/gpio_sync_edge.sv | 36 +++
 rtl/gpio_bank.sv | 168 ++++++++++++++++
 tb/tb_gpio_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared constants, register offsets and bus decode helpers for the GPIO bank.
package gpio_bank_pkg;

  localparam int unsigned N_CH_MAX = 8;
  localparam int unsigned W_MAX    = 32;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned RSEL_W   = 3;

  typedef logic [RSEL_W-1:0] rsel_t;

  localparam rsel_t REG_OUT     = 3'd0;
  localparam rsel_t REG_DIR     = 3'd1;
  localparam rsel_t REG_IN      = 3'd2;
  localparam rsel_t REG_RISE_EN = 3'd3;
  localparam rsel_t REG_FALL_EN = 3'd4;
  localparam rsel_t REG_STATUS  = 3'd5;
  localparam rsel_t REG_SET     = 3'd6;
  localparam rsel_t REG_CLR     = 3'd7;

  // Decoded view of a bus address: channel select and register select.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    rsel_t           rsel;
  } bus_dec_t;

  // Split the word address (byte address without its two LSBs) into fields.
  function automatic bus_dec_t decode_addr(input logic [ADDR_W-3:0] word_addr);
    bus_dec_t d;
    d.ch   = word_addr[ADDR_W-3 -: CH_W];
    d.rsel = word_addr[RSEL_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-channel pin synchronizer with one-cycle delay copy and edge vectors.
module gpio_sync_edge
  import gpio_bank_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise_c,
  output logic [W-1:0] fall_c
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] dly_q;

  // Two-flop synchronizer followed by the delay flop used for edge compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~dly_q;
  assign fall_c = ~sync_q & dly_q;

endmodule

// File: rtl/gpio_bank.sv
// Multi-channel GPIO bank: register decode, per-channel registers, edge
// interrupts and a registered read port.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                err,
  input  logic [N_CH*W-1:0]   gpio_in,
  output logic [N_CH*W-1:0]   gpio_out,
  output logic [N_CH*W-1:0]   gpio_oe,
  output logic                irq
);

  // Architectural per-channel registers.
  logic [W-1:0] out_q     [N_CH];
  logic [W-1:0] dir_q     [N_CH];
  logic [W-1:0] rise_en_q [N_CH];
  logic [W-1:0] fall_en_q [N_CH];
  logic [W-1:0] status_q  [N_CH];

  // Next-state values.
  logic [W-1:0] out_nxt     [N_CH];
  logic [W-1:0] dir_nxt     [N_CH];
  logic [W-1:0] rise_en_nxt [N_CH];
  logic [W-1:0] fall_en_nxt [N_CH];
  logic [W-1:0] status_nxt  [N_CH];
  logic         irq_nxt;

  // Synchronized pins and edge vectors from the per-channel front ends.
  logic [W-1:0] sync_a [N_CH];
  logic [W-1:0] rise_a [N_CH];
  logic [W-1:0] fall_a [N_CH];

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;
  logic              irq_q;

  bus_dec_t          dec;
  logic              ch_ok;
  logic [W-1:0]      wval;
  logic [W-1:0]      rd_sel;
  logic              unused_addr_lsb;

  assign dec             = decode_addr(addr[ADDR_W-1:2]);
  assign ch_ok           = (32'(dec.ch) < N_CH);
  assign wval            = wdata[W-1:0];
  assign unused_addr_lsb = ^addr[1:0];

  if (W < DATA_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[DATA_W-1:W];
  end

  // One synchronizer/edge detector per channel, plus pin output mapping.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gpio_sync_edge #(.W(W)) u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .pin    (gpio_in[c*W +: W]),
      .sync   (sync_a[c]),
      .rise_c (rise_a[c]),
      .fall_c (fall_a[c])
    );
    assign gpio_out[c*W +: W] = out_q[c];
    assign gpio_oe[c*W +: W]  = dir_q[c];
  end

  // Register write decode and status update; edge sets win over W1C.
  always_comb begin
    irq_nxt = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      out_nxt[c]     = out_q[c];
      dir_nxt[c]     = dir_q[c];
      rise_en_nxt[c] = rise_en_q[c];
      fall_en_nxt[c] = fall_en_q[c];
      status_nxt[c]  = status_q[c];
      if (we && (dec.ch == CH_W'(c))) begin
        case (dec.rsel)
          REG_OUT:     out_nxt[c]     = wval;
          REG_DIR:     dir_nxt[c]     = wval;
          REG_RISE_EN: rise_en_nxt[c] = wval;
          REG_FALL_EN: fall_en_nxt[c] = wval;
          REG_STATUS:  status_nxt[c]  = status_q[c] & ~wval;
          REG_SET:     out_nxt[c]     = out_q[c] | wval;
          REG_CLR:     out_nxt[c]     = out_q[c] & ~wval;
          default:     ;
        endcase
      end
      status_nxt[c] = status_nxt[c]
                    | (rise_a[c] & rise_en_q[c])
                    | (fall_a[c] & fall_en_q[c]);
      irq_nxt = irq_nxt | (|status_nxt[c]);
    end
  end

  // Read mux over pre-write register contents; unmapped reads return zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (dec.ch == CH_W'(c)) begin
        case (dec.rsel)
          REG_OUT:     rd_sel = out_q[c];
          REG_DIR:     rd_sel = dir_q[c];
          REG_IN:      rd_sel = sync_a[c];
          REG_RISE_EN: rd_sel = rise_en_q[c];
          REG_FALL_EN: rd_sel = fall_en_q[c];
          REG_STATUS:  rd_sel = status_q[c];
          default:     rd_sel = '0;
        endcase
      end
    end
  end

  // Channel register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        out_q[c]     <= '0;
        dir_q[c]     <= '0;
        rise_en_q[c] <= '0;
        fall_en_q[c] <= '0;
        status_q[c]  <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        out_q[c]     <= out_nxt[c];
        dir_q[c]     <= dir_nxt[c];
        rise_en_q[c] <= rise_en_nxt[c];
        fall_en_q[c] <= fall_en_nxt[c];
        status_q[c]  <= status_nxt[c];
      end
      irq_q <= irq_nxt;
    end
  end

  // Registered read response and out-of-range access error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= re;
      err_q    <= (we | re) & ~ch_ok;
      if (re) begin
        rdata_q <= ch_ok ? DATA_W'(rd_sel) : '0;
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (N_CH=2, W=32).
module tb_gpio_bank;

  localparam int unsigned N_CH = 2;
  localparam int unsigned W    = 32;

  localparam int R_OUT    = 0;
  localparam int R_DIR    = 1;
  localparam int R_IN     = 2;
  localparam int R_RISE   = 3;
  localparam int R_FALL   = 4;
  localparam int R_STATUS = 5;
  localparam int R_SET    = 6;
  localparam int R_CLR    = 7;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                we = 1'b0;
  logic                re = 1'b0;
  logic [7:0]          addr = '0;
  logic [31:0]         wdata = '0;
  logic [31:0]         rdata;
  logic                rvalid;
  logic                err;
  logic [N_CH*W-1:0]   gpio_in = '0;
  logic [N_CH*W-1:0]   gpio_out;
  logic [N_CH*W-1:0]   gpio_oe;
  logic                irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_bank #(.N_CH(N_CH), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  function automatic logic [7:0] ra(input int ch, input int r);
    logic [7:0] a;
    a = {3'(ch), 3'(r), 2'b00};
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    addr  = ra(ch, r);
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int r, input logic [31:0] exp);
    addr = ra(ch, r);
    re   = 1'b1;
    tick();
    re   = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid), 64'h1);
    check(tag, 64'(rdata), 64'(exp));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst.gpio_out", gpio_out, 64'h0);
    check("rst.gpio_oe", gpio_oe, 64'h0);
    check("rst.irq", 64'(irq), 64'h0);
    check("rst.rdata", 64'(rdata), 64'h0);
    check("rst.rvalid", 64'(rvalid), 64'h0);
    check("rst.err", 64'(err), 64'h0);
    rst = 1'b0;

    // DIR/OUT write and readback
    wr(0, R_DIR, 32'h0000_00FF);
    wr(0, R_OUT, 32'h0000_00A5);
    check("oe.ch0", gpio_oe, 64'h0000_0000_0000_00FF);
    check("out.ch0", gpio_out, 64'h0000_0000_0000_00A5);
    check("rvalid.idle", 64'(rvalid), 64'h0);
    rd_chk("rd.out", 0, R_OUT, 32'h0000_00A5);
    rd_chk("rd.dir", 0, R_DIR, 32'h0000_00FF);
    tick();
    check("rvalid.drop", 64'(rvalid), 64'h0);
    check("rdata.hold", 64'(rdata), 64'h0000_00FF);

    // SET / CLR
    wr(0, R_OUT, 32'h0000_00F0);
    wr(0, R_SET, 32'h0000_000F);
    check("set.out", gpio_out, 64'h0000_0000_0000_00FF);
    wr(0, R_CLR, 32'h0000_0030);
    check("clr.out", gpio_out, 64'h0000_0000_0000_00CF);
    rd_chk("rd.set", 0, R_SET, 32'h0);
    rd_chk("rd.clr", 0, R_CLR, 32'h0);

    // Simultaneous read and write returns the old value
    addr  = ra(0, R_OUT);
    wdata = 32'h0000_0055;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    check("rw.rdata", 64'(rdata), 64'h0000_00CF);
    check("rw.out", gpio_out, 64'h0000_0000_0000_0055);

    // IN read through synchronizer; writes to IN ignored
    gpio_in[31:0] = 32'h1234_5678;
    tick();
    tick();
    wr(0, R_IN, 32'hFFFF_FFFF);
    rd_chk("rd.in", 0, R_IN, 32'h1234_5678);
    check("in.irq", 64'(irq), 64'h0);

    // Out-of-range channel
    addr = 8'h40;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    check("oor.rdata", 64'(rdata), 64'h0);
    check("oor.rvalid", 64'(rvalid), 64'h1);
    check("oor.err", 64'(err), 64'h1);
    tick();
    check("oor.err_drop", 64'(err), 64'h0);
    wr(2, R_OUT, 32'hFFFF_FFFF);
    check("oor.werr", 64'(err), 64'h1);
    check("oor.out", gpio_out, 64'h0000_0000_0000_0055);

    // Rising edge latency on ch1 bit 0
    wr(1, R_RISE, 32'h1);
    gpio_in[32] = 1'b1;
    tick();
    check("rise.e0.irq", 64'(irq), 64'h0);
    tick();
    check("rise.e1.irq", 64'(irq), 64'h0);
    tick();
    check("rise.e2.irq", 64'(irq), 64'h1);
    rd_chk("rise.status", 1, R_STATUS, 32'h1);
    wr(1, R_STATUS, 32'h1);
    check("w1c.irq", 64'(irq), 64'h0);

    // Falling edge coinciding with W1C: set wins
    wr(1, R_FALL, 32'h1);
    gpio_in[32] = 1'b0;
    tick();
    tick();
    wr(1, R_STATUS, 32'h1);
    check("fall_w1c.irq", 64'(irq), 64'h1);
    rd_chk("fall_w1c.status", 1, R_STATUS, 32'h1);
    wr(1, R_STATUS, 32'h1);
    check("fall_clr.irq", 64'(irq), 64'h0);

    // Disabling RISE_EN keeps pending status
    gpio_in[32] = 1'b1;
    tick();
    tick();
    tick();
    check("pend.irq", 64'(irq), 64'h1);
    wr(1, R_RISE, 32'h0);
    check("pend.irq_kept", 64'(irq), 64'h1);
    rd_chk("pend.status", 1, R_STATUS, 32'h1);
    wr(1, R_STATUS, 32'h1);
    check("pend.clr", 64'(irq), 64'h0);

    // Build STATUS=0x3 on ch1 and OUT=all ones on ch0, then reset mid-read
    wr(1, R_RISE, 32'h3);
    gpio_in[33:32] = 2'b10;
    tick();
    tick();
    tick();
    rd_chk("st3.status", 1, R_STATUS, 32'h3);
    wr(0, R_OUT, 32'hFFFF_FFFF);
    check("pre_rst.out", gpio_out, 64'h0000_0000_FFFF_FFFF);
    check("pre_rst.irq", 64'(irq), 64'h1);
    addr = ra(0, R_OUT);
    re   = 1'b1;
    #2;
    rst  = 1'b1;
    #1;
    check("arst.gpio_out", gpio_out, 64'h0);
    check("arst.gpio_oe", gpio_oe, 64'h0);
    check("arst.irq", 64'(irq), 64'h0);
    check("arst.rvalid", 64'(rvalid), 64'h0);
    check("arst.rdata", 64'(rdata), 64'h0);
    re = 1'b0;
    tick();
    tick();

    // First access right after release; high pins set no status
    rst = 1'b0;
    wr(0, R_OUT, 32'h0000_003C);
    check("rel.rvalid", 64'(rvalid), 64'h0);
    check("rel.out", gpio_out, 64'h0000_0000_0000_003C);
    tick();
    tick();
    tick();
    check("rel.irq", 64'(irq), 64'h0);
    rd_chk("rel.status", 1, R_STATUS, 32'h0);
    rd_chk("rel.in", 1, R_IN, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
